gesture_box_locator: RTL and testbench
======================================

// Module: gesture_box_locator
// PURPOSE
//  Per-frame bounding-box locator for the gesture path. Scans the binarised skin-mask pixel
//  stream, tracks min/max x/y of accepted mask pixels inside the ROI, and latches box
//  edges plus centre at each frame boundary. Outputs drive vga_display's centre_x/centre_y
//  and x/y_min/max_locate overlay inputs.
// PARAMETERS
//  X_MIN       100   ROI left column (inclusive)
//  X_MAX       500   ROI right column (inclusive)
//  Y_MIN       0     ROI top row (inclusive)
//  Y_MAX       400   ROI bottom row (inclusive)
//  MIN_PIXELS  64    accepted-pixel count needed for a valid box
//  MISS_LIMIT  8     consecutive invalid frames before the held box is cleared
//  RUN_LEN     4     run length for the optional run filter (2..15)
// PORTS
//  clk           in   1   pixel clock
//  rst_n         in   1   async active-low reset
//  frame_sync    in   1   level frame marker; rising edge = frame boundary
//  pix_valid     in   1   lcd_x/lcd_y/mask_bit valid this cycle
//  lcd_x         in   12  pixel column
//  lcd_y         in   12  pixel row
//  mask_bit      in   1   1 = skin pixel
//  x_min_locate  out  10  latched box left edge
//  x_max_locate  out  10  latched box right edge
//  y_min_locate  out  10  latched box top edge
//  y_max_locate  out  10  latched box bottom edge
//  centre_x      out  10  (x_min+x_max)>>1
//  centre_y      out  10  (y_min+y_max)>>1
//  box_valid     out  1   1 = last closed frame met MIN_PIXELS
// BEHAVIOUR
//  - Clock: single clk. Reset: async active-low rst_n. All outputs 0 in reset; working min
//    regs = 10'h3FF, working max regs = 0, pix_cnt = 0, miss_cnt = 0.
//  - Stage 1: register frame_sync, pix_valid, lcd_x, lcd_y, mask_bit.
//    Edge = sync_q & ~sync_qq.
//  - Accept: registered pix_valid & mask_bit & x,y inside ROI & x,y < 1024. Stage 2: on accept,
//    wmin = min(wmin,coord), wmax = max(wmax,coord), pix_cnt += 1, saturating at 20'hFFFFF.
//  - Frame close on edge (stage 2): if pix_cnt >= MIN_PIXELS -> load outputs from working regs,
//    centre = 11-bit sum >> 1, box_valid = 1, miss_cnt = 0. Else box_valid = 0, outputs hold,
//    miss_cnt+1 (saturate); when miss_cnt reaches MISS_LIMIT, all six coordinate outputs -> 0.
//  - Same cycle: working regs reinit, then merge any pixel accepted in that cycle, i.e. an edge-
//    cycle pixel belongs to the new frame (wmin = wmax = coord, pix_cnt = 1).
//  - Latency: edge at frame_sync input -> outputs updated 3 clk later. Outputs are stable
//    between closes and change on one cycle only (no tearing across the six values).
//  - Single accepted pixel -> min == max on both axes; centre equals that pixel.
//  - Reset mid-frame discards the partial frame; first close after reset uses only
//    post-reset pixels.
//  - No frame_sync edge -> working regs keep accumulating; outputs never change.
// CONFIGURATION
//  BOX_RUN_FILTER_EN defined: a pixel is accepted only when it completes a run of RUN_LEN
//   consecutive accepted-candidate pixels on one row. Run counter clears on mask 0,
//   pix_valid 0, ROI exit, or lcd_y change vs previous valid pixel. On reaching RUN_LEN,
//   x_min candidate = x-(RUN_LEN-1); every later pixel of that run is accepted normally.
//   pix_cnt counts accepted pixels only, adding RUN_LEN on the completing pixel.
//   Adds 1 pipeline cycle, so frame-close latency = 4 clk.
//  BOX_RUN_FILTER_EN undefined: every candidate pixel accepted directly; run logic absent.
// TESTING
//  1 Frame with mask block x=200..299, y=50..149, then edge -> x_min 200, x_max 299, y_min 50,
//    y_max 149, centre 249/99, box_valid 1, exactly 3 clk after edge.
//  2 Frame with 10 mask pixels (<64) after test 1 -> box_valid 0, outputs hold 200/299/50/149;
//    8 such frames -> all six outputs 0 on the 8th close.
//  3 Mask pixels at x=50 and x=600 (outside ROI) plus block as in test 1 -> identical result
//    to test 1.
//  4 Accepted pixel at (300,60) in the edge cycle -> next close reports box containing
//    (300,60). The closing frame excludes it.
//  5 Assert rst_n low mid-frame for 2 clk -> all outputs 0 immediately, async. The following
//    frame reports only post-reset pixels.
//  6 BOX_RUN_FILTER_EN with RUN_LEN 4: isolated 3-pixel runs plus 8-pixel runs at
//    x=120..127 -> only the 8-pixel runs accepted, x_min 120, close latency 4 clk.

Source files
------------

// File: rtl/gesture_box_locator.sv
// Per-frame bounding-box locator: tracks min/max of accepted skin-mask pixels inside the ROI and latches box + centre on frame_sync rising edges.
// Optional horizontal run filter (adds one pipeline stage) is enabled by defining BOX_RUN_FILTER_EN.
module gesture_box_locator #(
    parameter int X_MIN      = 100,
    parameter int X_MAX      = 500,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 400,
    parameter int MIN_PIXELS = 64,
    parameter int MISS_LIMIT = 8,
    parameter int RUN_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_sync,
    input  logic        pix_valid,
    input  logic [11:0] lcd_x,
    input  logic [11:0] lcd_y,
    input  logic        mask_bit,
    output logic [9:0]  x_min_locate,
    output logic [9:0]  x_max_locate,
    output logic [9:0]  y_min_locate,
    output logic [9:0]  y_max_locate,
    output logic [9:0]  centre_x,
    output logic [9:0]  centre_y,
    output logic        box_valid
);

    localparam int IncW = $clog2(RUN_LEN + 1);

    logic        sync_q;
    logic        sync_qq;
    logic        pixValid_q;
    logic        mask_q;
    logic [11:0] lcdX_q;
    logic [11:0] lcdY_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 1'b0;
            sync_qq    <= 1'b0;
            pixValid_q <= 1'b0;
            mask_q     <= 1'b0;
            lcdX_q     <= '0;
            lcdY_q     <= '0;
        end else begin
            sync_q     <= frame_sync;
            sync_qq    <= sync_q;
            pixValid_q <= pix_valid;
            mask_q     <= mask_bit;
            lcdX_q     <= lcd_x;
            lcdY_q     <= lcd_y;
        end
    end

    logic inRoi;
    logic cand;
    logic frameEdge;

    always_comb begin
        inRoi = (int'(lcdX_q) >= X_MIN) && (int'(lcdX_q) <= X_MAX) &&
                (int'(lcdY_q) >= Y_MIN) && (int'(lcdY_q) <= Y_MAX) &&
                (lcdX_q < 12'd1024) && (lcdY_q < 12'd1024);
        cand      = pixValid_q && mask_q && inRoi;
        frameEdge = sync_q && !sync_qq;
    end

    logic            acc;
    logic [9:0]      accXlo;
    logic [9:0]      accXhi;
    logic [9:0]      accY;
    logic [IncW-1:0] accInc;
    logic            accEdge;

`ifdef BOX_RUN_FILTER_EN
    logic [IncW-1:0] runCnt_q;
    logic [IncW-1:0] runCnt_d;
    logic [11:0]     prevY_q;
    logic            runCont;
    logic            runFirst;
    logic            fAcc_q;
    logic            fEdge_q;
    logic [9:0]      fXlo_q;
    logic [9:0]      fXhi_q;
    logic [9:0]      fY_q;
    logic [IncW-1:0] fInc_q;

    // The completing pixel back-fills the whole run, so its left edge is RUN_LEN-1 columns earlier.
    always_comb begin
        runCont  = (runCnt_q != '0) && (lcdY_q == prevY_q);
        runCnt_d = '0;
        if (cand) begin
            if (!runCont) begin
                runCnt_d = IncW'(1);
            end else if (int'(runCnt_q) < RUN_LEN) begin
                runCnt_d = runCnt_q + IncW'(1);
            end else begin
                runCnt_d = runCnt_q;
            end
        end
        runFirst = cand && (int'(runCnt_d) == RUN_LEN) &&
                   !(runCont && (int'(runCnt_q) == RUN_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runCnt_q <= '0;
            prevY_q  <= '0;
            fAcc_q   <= 1'b0;
            fEdge_q  <= 1'b0;
            fXlo_q   <= '0;
            fXhi_q   <= '0;
            fY_q     <= '0;
            fInc_q   <= '0;
        end else begin
            runCnt_q <= runCnt_d;
            if (pixValid_q) begin
                prevY_q <= lcdY_q;
            end
            fAcc_q  <= cand && (int'(runCnt_d) >= RUN_LEN);
            fEdge_q <= frameEdge;
            fXhi_q  <= lcdX_q[9:0];
            fXlo_q  <= runFirst ? (lcdX_q[9:0] - 10'(RUN_LEN - 1)) : lcdX_q[9:0];
            fY_q    <= lcdY_q[9:0];
            fInc_q  <= runFirst ? IncW'(RUN_LEN) : IncW'(1);
        end
    end

    assign acc     = fAcc_q;
    assign accXlo  = fXlo_q;
    assign accXhi  = fXhi_q;
    assign accY    = fY_q;
    assign accInc  = fInc_q;
    assign accEdge = fEdge_q;
`else
    assign acc     = cand;
    assign accXlo  = lcdX_q[9:0];
    assign accXhi  = lcdX_q[9:0];
    assign accY    = lcdY_q[9:0];
    assign accInc  = IncW'(1);
    assign accEdge = frameEdge;
`endif

    logic [9:0]  wXmin_q, wXmax_q, wYmin_q, wYmax_q;
    logic [9:0]  wXmin_d, wXmax_d, wYmin_d, wYmax_d;
    logic [19:0] pixCnt_q;
    logic [19:0] pixCnt_d;
    logic [20:0] cntSum;

    // On a frame edge the working set restarts, and a pixel arriving in that cycle seeds the new frame.
    always_comb begin
        cntSum   = {1'b0, pixCnt_q} + 21'(accInc);
        wXmin_d  = wXmin_q;
        wXmax_d  = wXmax_q;
        wYmin_d  = wYmin_q;
        wYmax_d  = wYmax_q;
        pixCnt_d = pixCnt_q;
        if (accEdge) begin
            wXmin_d  = 10'h3FF;
            wXmax_d  = '0;
            wYmin_d  = 10'h3FF;
            wYmax_d  = '0;
            pixCnt_d = '0;
            if (acc) begin
                wXmin_d  = accXlo;
                wXmax_d  = accXhi;
                wYmin_d  = accY;
                wYmax_d  = accY;
                pixCnt_d = 20'(accInc);
            end
        end else if (acc) begin
            if (accXlo < wXmin_q) wXmin_d = accXlo;
            if (accXhi > wXmax_q) wXmax_d = accXhi;
            if (accY < wYmin_q)   wYmin_d = accY;
            if (accY > wYmax_q)   wYmax_d = accY;
            pixCnt_d = cntSum[20] ? 20'hFFFFF : cntSum[19:0];
        end
    end

    logic       closePend_q;
    logic       closeOk_q;
    logic [9:0] cXmin_q, cXmax_q, cYmin_q, cYmax_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wXmin_q     <= 10'h3FF;
            wXmax_q     <= '0;
            wYmin_q     <= 10'h3FF;
            wYmax_q     <= '0;
            pixCnt_q    <= '0;
            closePend_q <= 1'b0;
            closeOk_q   <= 1'b0;
            cXmin_q     <= '0;
            cXmax_q     <= '0;
            cYmin_q     <= '0;
            cYmax_q     <= '0;
        end else begin
            wXmin_q     <= wXmin_d;
            wXmax_q     <= wXmax_d;
            wYmin_q     <= wYmin_d;
            wYmax_q     <= wYmax_d;
            pixCnt_q    <= pixCnt_d;
            closePend_q <= accEdge;
            if (accEdge) begin
                closeOk_q <= int'(pixCnt_q) >= MIN_PIXELS;
                cXmin_q   <= wXmin_q;
                cXmax_q   <= wXmax_q;
                cYmin_q   <= wYmin_q;
                cYmax_q   <= wYmax_q;
            end
        end
    end

    logic [10:0] sumX;
    logic [10:0] sumY;
    logic [7:0]  missCnt_q;
    logic [7:0]  missCnt_d;

    always_comb begin
        sumX      = {1'b0, cXmin_q} + {1'b0, cXmax_q};
        sumY      = {1'b0, cYmin_q} + {1'b0, cYmax_q};
        missCnt_d = (missCnt_q == 8'hFF) ? missCnt_q : missCnt_q + 8'd1;
    end

    // All six coordinates update together from the snapshot so the overlay never sees a torn box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min_locate <= '0;
            x_max_locate <= '0;
            y_min_locate <= '0;
            y_max_locate <= '0;
            centre_x     <= '0;
            centre_y     <= '0;
            box_valid    <= 1'b0;
            missCnt_q    <= '0;
        end else if (closePend_q) begin
            if (closeOk_q) begin
                x_min_locate <= cXmin_q;
                x_max_locate <= cXmax_q;
                y_min_locate <= cYmin_q;
                y_max_locate <= cYmax_q;
                centre_x     <= sumX[10:1];
                centre_y     <= sumY[10:1];
                box_valid    <= 1'b1;
                missCnt_q    <= '0;
            end else begin
                box_valid <= 1'b0;
                missCnt_q <= missCnt_d;
                if (int'(missCnt_d) >= MISS_LIMIT) begin
                    x_min_locate <= '0;
                    x_max_locate <= '0;
                    y_min_locate <= '0;
                    y_max_locate <= '0;
                    centre_x     <= '0;
                    centre_y     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gesture_box_locator.sv
// Directed testbench for gesture_box_locator: hand-computed boxes, frame-close latency, miss clearing and async reset.
`timescale 1ns/1ps
module tb_gesture_box_locator;

`ifdef BOX_RUN_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_sync = 1'b0;
    logic        pix_valid = 1'b0;
    logic [11:0] lcd_x = '0;
    logic [11:0] lcd_y = '0;
    logic        mask_bit = 1'b0;
    logic [9:0]  x_min_locate, x_max_locate, y_min_locate, y_max_locate, centre_x, centre_y;
    logic        box_valid;

    int nCompared = 0;
    int nMismatched = 0;
    logic [60:0] preBox;
    logic [60:0] postBox;
    wire  [60:0] obsBox = {x_min_locate, x_max_locate, y_min_locate, y_max_locate,
                           centre_x, centre_y, box_valid};

    gesture_box_locator dut (
        .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .pix_valid(pix_valid),
        .lcd_x(lcd_x), .lcd_y(lcd_y), .mask_bit(mask_bit),
        .x_min_locate(x_min_locate), .x_max_locate(x_max_locate),
        .y_min_locate(y_min_locate), .y_max_locate(y_max_locate),
        .centre_x(centre_x), .centre_y(centre_y), .box_valid(box_valid)
    );

    always #5 clk = ~clk;

    // Packed layout matches obsBox: xmin, xmax, ymin, ymax, cx, cy, valid.
    function automatic logic [60:0] boxOf(input int xmin, input int xmax, input int ymin,
                                          input int ymax, input int cx, input int cy, input logic v);
        return {10'(xmin), 10'(xmax), 10'(ymin), 10'(ymax), 10'(cx), 10'(cy), v};
    endfunction

    task automatic send_pix(input int x, input int y, input logic m);
        pix_valid = 1'b1;
        lcd_x     = 12'(x);
        lcd_y     = 12'(y);
        mask_bit  = m;
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_block(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                send_pix(x, y, 1'b1);
    endtask

    // Raises frame_sync (optionally with a pixel in that same cycle); preBox is sampled one
    // cycle before the expected update, postBox on the cycle the update must appear.
    task automatic close_frame(input bit edgePix, input int px, input int py);
        frame_sync = 1'b1;
        if (edgePix) begin
            pix_valid = 1'b1;
            lcd_x     = 12'(px);
            lcd_y     = 12'(py);
            mask_bit  = 1'b1;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        repeat (LAT - 2) begin
            @(posedge clk); #1;
        end
        preBox = obsBox;
        @(posedge clk); #1;
        postBox = obsBox;
        frame_sync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if (obsBox !== 61'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %h want %h", obsBox, 61'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_block_frame();
        logic [60:0] expBox;
        expBox = boxOf(200, 299, 50, 149, 249, 99, 1'b1);
        send_block(200, 299, 50, 149);
        close_frame(1'b0, 0, 0);
        nCompared++;
        if (preBox !== 61'd0) begin
            nMismatched++;
            $display("[TB] FAIL block_early: got %h want %h", preBox, 61'd0);
        end
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL block_box: got %h want %h", postBox, expBox);
        end
    endtask

    task automatic test_miss_frames();
        logic [60:0] expBox;
        for (int f = 1; f <= 8; f++) begin
            for (int x = 200; x < 210; x++) send_pix(x, 60, 1'b1);
            close_frame(1'b0, 0, 0);
            expBox = (f < 8) ? boxOf(200, 299, 50, 149, 249, 99, 1'b0) : 61'd0;
            nCompared++;
            if (postBox !== expBox) begin
                nMismatched++;
                $display("[TB] FAIL miss_frame%0d: got %h want %h", f, postBox, expBox);
            end
        end
    endtask

    task automatic test_outside_roi();
        logic [60:0] expBox;
        expBox = boxOf(200, 299, 50, 149, 249, 99, 1'b1);
        send_pix(50, 100, 1'b1);
        send_pix(600, 100, 1'b1);
        send_pix(150, 30, 1'b0);
        send_block(200, 299, 50, 149);
        send_pix(200, 450, 1'b1);
        close_frame(1'b0, 0, 0);
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL roi_box: got %h want %h", postBox, expBox);
        end
    endtask

    task automatic test_threshold();
        logic [60:0] expBox;
        send_pix(99, 5, 1'b1);
        for (int x = 100; x <= 162; x++) send_pix(x, 5, 1'b1);
        close_frame(1'b0, 0, 0);
        expBox = boxOf(200, 299, 50, 149, 249, 99, 1'b0);
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL thresh_63: got %h want %h", postBox, expBox);
        end
        for (int x = 437; x <= 501; x++) send_pix(x, 400, 1'b1);
        send_pix(450, 401, 1'b1);
        close_frame(1'b0, 0, 0);
        expBox = boxOf(437, 500, 400, 400, 468, 400, 1'b1);
        nCompared++;
        if (preBox !== boxOf(200, 299, 50, 149, 249, 99, 1'b0)) begin
            nMismatched++;
            $display("[TB] FAIL thresh_early: got %h want %h", preBox,
                     boxOf(200, 299, 50, 149, 249, 99, 1'b0));
        end
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL thresh_64: got %h want %h", postBox, expBox);
        end
    endtask

    task automatic test_edge_pixel();
        logic [60:0] expBox;
        send_block(400, 409, 200, 209);
`ifdef BOX_RUN_FILTER_EN
        for (int x = 297; x <= 299; x++) send_pix(x, 60, 1'b1);
`endif
        close_frame(1'b1, 300, 60);
        expBox = boxOf(400, 409, 200, 209, 404, 204, 1'b1);
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL edge_closing: got %h want %h", postBox, expBox);
        end
        send_block(310, 319, 70, 79);
        close_frame(1'b0, 0, 0);
`ifdef BOX_RUN_FILTER_EN
        expBox = boxOf(297, 319, 60, 79, 308, 69, 1'b1);
`else
        expBox = boxOf(300, 319, 60, 79, 309, 69, 1'b1);
`endif
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL edge_next: got %h want %h", postBox, expBox);
        end
    endtask

    task automatic test_async_reset();
        logic [60:0] expBox;
        send_block(450, 459, 380, 384);
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (obsBox !== 61'd0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset: got %h want %h", obsBox, 61'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_block(120, 129, 300, 309);
        close_frame(1'b0, 0, 0);
        expBox = boxOf(120, 129, 300, 309, 124, 304, 1'b1);
        nCompared++;
        if (preBox !== 61'd0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_early: got %h want %h", preBox, 61'd0);
        end
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_box: got %h want %h", postBox, expBox);
        end
    endtask

`ifdef BOX_RUN_FILTER_EN
    task automatic test_run_filter();
        logic [60:0] expBox;
        for (int y = 10; y <= 17; y++) begin
            for (int x = 120; x <= 127; x++) send_pix(x, y, 1'b1);
            send_pix(130, y, 1'b0);
            for (int x = 140; x <= 142; x++) send_pix(x, y, 1'b1);
            send_pix(143, y, 1'b0);
            for (int x = 160; x <= 162; x++) send_pix(x, y, 1'b1);
        end
        close_frame(1'b0, 0, 0);
        expBox = boxOf(120, 127, 10, 17, 123, 13, 1'b1);
        nCompared++;
        if (preBox !== boxOf(120, 129, 300, 309, 124, 304, 1'b1)) begin
            nMismatched++;
            $display("[TB] FAIL run_early: got %h want %h", preBox,
                     boxOf(120, 129, 300, 309, 124, 304, 1'b1));
        end
        nCompared++;
        if (postBox !== expBox) begin
            nMismatched++;
            $display("[TB] FAIL run_box: got %h want %h", postBox, expBox);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_block_frame();
        test_miss_frames();
        test_outside_roi();
        test_threshold();
        test_edge_pixel();
        test_async_reset();
`ifdef BOX_RUN_FILTER_EN
        test_run_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
